// File: rtl/mem_master_pkg.sv
// Shared types and constants for the memory master: FSM states, request op codes, sizing.
package mem_master_pkg;

    localparam int MEM_DEPTH_DEF = 1024;
    localparam int ADDR_W        = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA,
        ST_CLEAR,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/mem_clr_addr_gen.sv
// Wrap-around word address counter for range clears: loaded with base/len, steps once per clear cycle.
// remaining counts words still to clear; done is set when nothing is left.
module mem_clr_addr_gen #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [9:0]        len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [9:0]        remaining,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
        end else if (step && (remaining != 10'd0)) begin
            addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            remaining <= remaining - 10'd1;
        end
    end

    assign done = (remaining == 10'd0);

endmodule

// File: rtl/mem_master.sv
// Sequences one CPU request into an instruction fetch plus optional load, store or range clear.
// Out-of-range addresses flag rsp_err and suppress the access but keep the normal latency.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [9:0]  req_len,
    output logic        rsp_valid,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Read_PC,
    output logic [31:0] R_W_Addr,
    output logic [31:0] DataWrite,
    output logic        Op2En,
    output logic        Op2RW,
    output logic        M_Clear,
    input  logic [31:0] Instruction,
    input  logic [31:0] DataRead
);

    localparam logic [31:0] DEPTH32 = 32'(MEM_DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  op;
    logic [31:0] pc, addr, wdata;
    logic        pc_bad, addr_bad;
    logic        accept, in_pc_bad, in_addr_bad;
    logic [ADDR_W-1:0] clr_addr;
    logic [9:0]  clr_remaining;
    logic        clr_done;

    assign accept      = req_valid && req_ready;
    assign in_pc_bad   = (req_pc >= DEPTH32);
    // A plain fetch never touches req_addr, so it cannot fault on it.
    assign in_addr_bad = (req_op != OP_FETCH) && (req_addr >= DEPTH32);

    mem_clr_addr_gen #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_clr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .base      (req_addr[ADDR_W-1:0]),
        .len       (req_len),
        .step      (state == ST_CLEAR),
        .addr      (clr_addr),
        .remaining (clr_remaining),
        .done      (clr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op        <= OP_FETCH;
            pc        <= '0;
            addr      <= '0;
            wdata     <= '0;
            pc_bad    <= 1'b0;
            addr_bad  <= 1'b0;
            rsp_instr <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op        <= req_op;
                pc        <= req_pc;
                addr      <= req_addr;
                wdata     <= req_wdata;
                pc_bad    <= in_pc_bad;
                addr_bad  <= in_addr_bad;
                rsp_instr <= '0;
                rsp_rdata <= '0;
                rsp_err   <= in_pc_bad || in_addr_bad;
            end
            if (state == ST_FETCH) begin
                rsp_instr <= pc_bad ? '0 : Instruction;
            end
            if ((state == ST_DATA) && (op == OP_LOAD) && !addr_bad) begin
                rsp_rdata <= DataRead;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        Read_PC   = '0;
        R_W_Addr  = '0;
        DataWrite = '0;
        Op2En     = 1'b0;
        Op2RW     = 1'b0;
        M_Clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                Read_PC = pc_bad ? '0 : pc;
                if ((op == OP_LOAD) || (op == OP_STORE))     state_nxt = ST_DATA;
                else if ((op == OP_CLEAR) && !clr_done)      state_nxt = ST_CLEAR;
                else                                         state_nxt = ST_RESP;
            end
            ST_DATA: begin
                Op2En     = !addr_bad;
                Op2RW     = (op == OP_STORE);
                R_W_Addr  = addr;
                DataWrite = wdata;
                state_nxt = ST_RESP;
            end
            ST_CLEAR: begin
                M_Clear  = !addr_bad;
                R_W_Addr = 32'(clr_addr);
                // Leave on the cycle that clears the final word.
                if (clr_remaining <= 10'd1) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 1024-word memory attached to its memory ports.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_pc, req_addr, req_wdata;
    logic [9:0]  req_len;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_instr, rsp_rdata;
    logic [31:0] Read_PC, R_W_Addr, DataWrite;
    logic        Op2En, Op2RW, M_Clear;
    logic [31:0] Instruction, DataRead;

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;
    int clr_cnt, op2en_cnt, op2rw_cnt, rsp_cnt, both_cnt;
    logic [31:0] clr_q[$];
    logic busy_ready;
    int lat;

    always #5 clk = ~clk;

    mem_master #(.MEM_DEPTH(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_pc(req_pc), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Read_PC(Read_PC), .R_W_Addr(R_W_Addr), .DataWrite(DataWrite),
        .Op2En(Op2En), .Op2RW(Op2RW), .M_Clear(M_Clear),
        .Instruction(Instruction), .DataRead(DataRead)
    );

    assign Instruction = mem[Read_PC[9:0]];
    assign DataRead    = mem[R_W_Addr[9:0]];

    always @(posedge clk) begin
        if (Op2En && Op2RW) mem[R_W_Addr[9:0]] <= DataWrite;
        if (M_Clear)        mem[R_W_Addr[9:0]] <= 32'h0;
        if (M_Clear) begin clr_cnt++; clr_q.push_back(R_W_Addr); end
        if (Op2En) op2en_cnt++;
        if (Op2En && Op2RW) op2rw_cnt++;
        if (Op2En && M_Clear) both_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        clr_cnt = 0; op2en_cnt = 0; op2rw_cnt = 0; rsp_cnt = 0;
        clr_q.delete();
    endtask

    // Issues one request and returns the accept-edge to rsp_valid distance in cycles (99 on timeout).
    task automatic do_req(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [9:0] len, output int l);
        @(negedge clk);
        clr_mon();
        req_valid = 1'b1; req_op = op; req_pc = pc; req_addr = addr;
        req_wdata = wdata; req_len = len;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 2'b11; req_pc = 32'hFFFF_FFFF;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hBAD0_BAD0; req_len = 10'h3FF;
        l = 99;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) busy_ready = req_ready;
            if (rsp_valid) begin l = i; break; end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        both_cnt = 0;
        clr_mon();
        req_valid = 0; req_op = 0; req_pc = 0; req_addr = 0; req_wdata = 0; req_len = 0;
        reset = 1'b1;
        #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_clear", {29'b0, Op2En, M_Clear, Op2RW}, 32'd0);
        chk("reset_read_pc", Read_PC, 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Fetch only
        mem[5] = 32'hDEAD_BEEF;
        do_req(2'b00, 32'd5, 32'd3000, 32'd0, 10'd0, lat);
        chk("fetch_latency", lat, 32'd2);
        chk("fetch_busy_ready", {31'b0, busy_ready}, 32'd0);
        chk("fetch_instr", rsp_instr, 32'hDEAD_BEEF);
        chk("fetch_err", {31'b0, rsp_err}, 32'd0);
        chk("fetch_op2en", op2en_cnt, 32'd0);

        // Store then load
        do_req(2'b10, 32'd5, 32'd12, 32'h0000_1234, 10'd0, lat);
        chk("store_latency", lat, 32'd3);
        chk("store_op2en", op2en_cnt, 32'd1);
        chk("store_op2rw", op2rw_cnt, 32'd1);
        chk("store_mem", mem[12], 32'h0000_1234);
        do_req(2'b01, 32'd6, 32'd12, 32'd0, 10'd0, lat);
        chk("load_latency", lat, 32'd3);
        chk("load_rdata", rsp_rdata, 32'h0000_1234);
        chk("load_instr", rsp_instr, 32'h1000_0006);
        chk("load_op2rw", op2rw_cnt, 32'd0);
        repeat (4) @(negedge clk);
        chk("load_rdata_hold", rsp_rdata, 32'h0000_1234);
        chk("rsp_pulse_once", rsp_cnt, 32'd1);

        // Wrapping clear
        do_req(2'b11, 32'd7, 32'd1020, 32'd0, 10'd8, lat);
        chk("clear_latency", lat, 32'd10);
        chk("clear_cycles", clr_cnt, 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("clear_addr%0d", i), (clr_q.size() > i) ? clr_q[i] : 32'hFFFF_FFFF,
                32'((1020 + i) % 1024));
        chk("clear_mem1023", mem[1023], 32'd0);
        chk("clear_mem0", mem[0], 32'd0);
        chk("clear_mem3", mem[3], 32'd0);
        chk("clear_mem4_kept", mem[4], 32'h1000_0004);
        chk("clear_mem1019_kept", mem[1019], 32'h1000_03FB);

        // Out-of-range load address
        do_req(2'b01, 32'd4, 32'd2000, 32'd0, 10'd0, lat);
        chk("badaddr_latency", lat, 32'd3);
        chk("badaddr_err", {31'b0, rsp_err}, 32'd1);
        chk("badaddr_op2en", op2en_cnt, 32'd0);
        chk("badaddr_rdata", rsp_rdata, 32'd0);
        chk("badaddr_instr", rsp_instr, 32'h1000_0004);

        // Out-of-range pc
        do_req(2'b00, 32'd4096, 32'd0, 32'd0, 10'd0, lat);
        chk("badpc_latency", lat, 32'd2);
        chk("badpc_err", {31'b0, rsp_err}, 32'd1);
        chk("badpc_instr", rsp_instr, 32'd0);

        // Zero-length clear
        do_req(2'b11, 32'd5, 32'd100, 32'd0, 10'd0, lat);
        chk("clr0_latency", lat, 32'd2);
        chk("clr0_cycles", clr_cnt, 32'd0);
        chk("clr0_err", {31'b0, rsp_err}, 32'd0);

        // Reset during the third clear cycle
        for (int i = 0; i < 6; i++) mem[i] = 32'hA000_0000 + i;
        @(negedge clk);
        clr_mon();
        req_valid = 1'b1; req_op = 2'b11; req_pc = 32'd1; req_addr = 32'd0; req_len = 10'd6;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_mclear_before", {31'b0, M_Clear}, 32'd1);
        chk("rst_mid_addr_before", R_W_Addr, 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_mid_mclear_after", {31'b0, M_Clear}, 32'd0);
        chk("rst_mid_op2en_after", {31'b0, Op2En}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_no_rsp", rsp_cnt, 32'd0);
        chk("rst_mid_mem1_cleared", mem[1], 32'd0);
        chk("rst_mid_mem3", mem[3], 32'hA000_0003);
        chk("rst_mid_mem4", mem[4], 32'hA000_0004);
        chk("rst_mid_mem5", mem[5], 32'hA000_0005);
        chk("op2en_mclear_overlap", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
